spad_bank_array: RTL and testbench

Parametrised, synchronous successor to the scratchpad register array: NBANK banks of DEPTH x WIDTH scratchpad RAM with per-byte write enables and one shared read port. The read port is registered and drives an active-low, wired-AND-style data bus. Same-cycle write-to-read bypass is write-first. An automatic clear sequencer zeroes every entry after reset. The block sits in the data-path module between the W bus (write data) and the R bus (read data), replacing the RTMP/GPR/IPR bank trio when NBANK=3.

---
 rtl/spad_bank_array.sv | 113 +++++++++++
 tb/tb_spad_bank_array.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_bank_array.sv
// Banked scratchpad RAM: NBANK x DEPTH x WIDTH, per-byte writes, one registered
// active-low wired-AND read port with write-first bypass, and a post-reset clear.
module spad_bank_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned NBANK = 3
) (
  input  logic                 clk_h,
  input  logic                 reset_l,
  input  logic [AW-1:0]        ra_h,
  input  logic [NBANK-1:0]     rsel_l,
  output logic [WIDTH-1:0]     rbus_l,
  output logic                 rvalid_h,
  input  logic [AW-1:0]        wa_h,
  input  logic [NBANK-1:0]     wsel_l,
  input  logic [WIDTH-1:0]     wbus_h,
  input  logic [WIDTH/8-1:0]   bw_l,
  output logic                 init_busy_h
);

  localparam int unsigned NBYTE = WIDTH / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [NBANK][DEPTH];

  logic [WIDTH-1:0] wmask_c;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] rd_and_c;
  logic             rd_any_c;

  // Expand the active-low byte enables into a bit mask of written bits.
  always_comb begin
    wmask_c = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      wmask_c[8*i +: 8] = {8{~bw_l[i]}};
    end
  end

  // Per-bank read word with write-first merge, then wired-AND of inverted words.
  always_comb begin
    word_c   = '0;
    rd_and_c = '1;
    rd_any_c = ~(&rsel_l);
    for (int unsigned b = 0; b < NBANK; b++) begin
      word_c = mem[b][ra_h];
      if (!wsel_l[b] && (wa_h == ra_h)) begin
        word_c = (word_c & ~wmask_c) | (wbus_h & wmask_c);
      end
      if (!rsel_l[b]) begin
        rd_and_c = rd_and_c & ~word_c;
      end
    end
  end

  // Control FSM and registered read port.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state       <= ST_INIT;
      cnt         <= '0;
      rbus_l      <= '1;
      rvalid_h    <= 1'b0;
      init_busy_h <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          rbus_l   <= '1;
          rvalid_h <= 1'b0;
          if (cnt == AW'(DEPTH - 1)) begin
            state       <= ST_RUN;
            cnt         <= '0;
            init_busy_h <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_RUN: begin
          rvalid_h <= rd_any_c;
          rbus_l   <= rd_and_c;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Storage: clear sweep during INIT, byte-masked user writes during RUN.
  always_ff @(posedge clk_h) begin
    if (state == ST_INIT) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        mem[b][cnt] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (!wsel_l[b]) begin
          for (int unsigned i = 0; i < NBYTE; i++) begin
            if (!bw_l[i]) begin
              mem[b][wa_h][8*i +: 8] <= wbus_h[8*i +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spad_bank_array.sv
// Bench for spad_bank_array: default instance (A) and a 16x8x5 instance (B),
// table-driven vectors feeding a scoreboard queue, plus clear/reset sequences.
module tb_spad_bank_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, DEPTH=16, AW=4, NBANK=3
  logic        rst_a;
  logic [3:0]  ra_a;
  logic [2:0]  rsel_a;
  logic [31:0] rbus_a;
  logic        rvalid_a;
  logic [3:0]  wa_a;
  logic [2:0]  wsel_a;
  logic [31:0] wbus_a;
  logic [3:0]  bw_a;
  logic        busy_a;

  // Instance B: WIDTH=16, DEPTH=8, AW=3, NBANK=5
  logic        rst_b;
  logic [2:0]  ra_b;
  logic [4:0]  rsel_b;
  logic [15:0] rbus_b;
  logic        rvalid_b;
  logic [2:0]  wa_b;
  logic [4:0]  wsel_b;
  logic [15:0] wbus_b;
  logic [1:0]  bw_b;
  logic        busy_b;

  spad_bank_array #(.WIDTH(32), .DEPTH(16), .AW(4), .NBANK(3)) u_a (
    .clk_h(clk), .reset_l(rst_a), .ra_h(ra_a), .rsel_l(rsel_a), .rbus_l(rbus_a),
    .rvalid_h(rvalid_a), .wa_h(wa_a), .wsel_l(wsel_a), .wbus_h(wbus_a),
    .bw_l(bw_a), .init_busy_h(busy_a)
  );

  spad_bank_array #(.WIDTH(16), .DEPTH(8), .AW(3), .NBANK(5)) u_b (
    .clk_h(clk), .reset_l(rst_b), .ra_h(ra_b), .rsel_l(rsel_b), .rbus_l(rbus_b),
    .rvalid_h(rvalid_b), .wa_h(wa_b), .wsel_l(wsel_b), .wbus_h(wbus_b),
    .bw_l(bw_b), .init_busy_h(busy_b)
  );

  typedef struct {
    logic [3:0]  ra;
    logic [4:0]  rsel;
    logic [3:0]  wa;
    logic [4:0]  wsel;
    logic [31:0] wbus;
    logic [3:0]  bw;
    logic [31:0] exp_rbus;
    logic        exp_rvalid;
  } vec_t;

  typedef struct {
    logic [31:0] rbus;
    logic        rvalid;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  vec_t tbl_a[15];
  vec_t tbl_b[9];

  function automatic vec_t mk(input logic [3:0] ra, input logic [4:0] rsel,
                              input logic [3:0] wa, input logic [4:0] wsel,
                              input logic [31:0] wbus, input logic [3:0] bw,
                              input logic [31:0] er, input logic ev);
    vec_t v;
    v.ra = ra; v.rsel = rsel; v.wa = wa; v.wsel = wsel;
    v.wbus = wbus; v.bw = bw; v.exp_rbus = er; v.exp_rvalid = ev;
    return v;
  endfunction

  task automatic check(input bit is_b, input string nm);
    exp_t        e;
    logic [31:0] act;
    logic        av;
    logic        ab;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
      return;
    end
    e   = exp_q.pop_front();
    act = is_b ? {16'h0, rbus_b} : rbus_a;
    av  = is_b ? rvalid_b : rvalid_a;
    ab  = is_b ? busy_b : busy_a;
    if (act !== e.rbus) begin
      n_fail++;
      $display("FAIL %s rbus_l: got %h expected %h", nm, act, e.rbus);
    end
    n_tests++;
    if (av !== e.rvalid) begin
      n_fail++;
      $display("FAIL %s rvalid_h: got %b expected %b", nm, av, e.rvalid);
    end
    n_tests++;
    if (ab !== e.busy) begin
      n_fail++;
      $display("FAIL %s init_busy_h: got %b expected %b", nm, ab, e.busy);
    end
  endtask

  task automatic drive(input bit is_b, input vec_t v);
    if (!is_b) begin
      ra_a = v.ra; rsel_a = v.rsel[2:0]; wa_a = v.wa; wsel_a = v.wsel[2:0];
      wbus_a = v.wbus; bw_a = v.bw;
    end else begin
      ra_b = v.ra[2:0]; rsel_b = v.rsel; wa_b = v.wa[2:0]; wsel_b = v.wsel;
      wbus_b = v.wbus[15:0]; bw_b = v.bw[1:0];
    end
  endtask

  // One edge: drive at negedge, queue the expectation, compare after the edge.
  task automatic apply(input bit is_b, input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    drive(is_b, v);
    e.rbus = v.exp_rbus; e.rvalid = v.exp_rvalid; e.busy = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(is_b, nm);
  endtask

  task automatic check_reset(input bit is_b, input string nm);
    exp_t e;
    e.rbus = is_b ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    e.rvalid = 1'b0; e.busy = 1'b1;
    exp_q.push_back(e);
    check(is_b, nm);
  endtask

  // Release reset and hold user writes/reads active through the clear sweep.
  task automatic run_clear(input bit is_b);
    int   depth;
    exp_t e;
    vec_t v;
    depth = is_b ? 8 : 16;
    @(negedge clk);
    if (is_b) rst_b = 1'b1; else rst_a = 1'b1;
    for (int k = 1; k <= depth; k++) begin
      v = mk(4'(k - 1), 5'h00, 4'(k - 1), 5'h00, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
      drive(is_b, v);
      e.rbus = is_b ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      e.rvalid = 1'b0;
      e.busy = (k < depth);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check(is_b, $sformatf("clear_edge%0d", k));
      if (k < depth) @(negedge clk);
    end
  endtask

  task automatic read_all(input bit is_b, input string tag);
    int          depth;
    int          nb;
    logic [4:0]  rs;
    logic [31:0] ones;
    depth = is_b ? 8 : 16;
    nb    = is_b ? 5 : 3;
    ones  = is_b ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    for (int b = 0; b < nb; b++) begin
      for (int a = 0; a < depth; a++) begin
        rs = 5'h1F & ~(5'd1 << b);
        apply(is_b, mk(4'(a), rs, 4'h0, 5'h1F, 32'h0, 4'hF, ones, 1'b1),
              $sformatf("%s_b%0d_a%0d", tag, b, a));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Instance A directed vectors, applied after its clear completes.
    tbl_a[0]  = mk(4'd0, 5'h1F, 4'd5, 5'h1D, 32'h1122_3344, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tbl_a[1]  = mk(4'd0, 5'h1F, 4'd5, 5'h1D, 32'hAABB_CCDD, 4'b1010, 32'hFFFF_FFFF, 1'b0);
    tbl_a[2]  = mk(4'd5, 5'h1D, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hEE44_CC22, 1'b1);
    tbl_a[3]  = mk(4'd0, 5'h1F, 4'd3, 5'h1E, 32'h0102_0304, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tbl_a[4]  = mk(4'd3, 5'h1E, 4'd3, 5'h1E, 32'hDEAD_BEEF, 4'b1100, 32'hFEFD_4110, 1'b1);
    tbl_a[5]  = mk(4'd3, 5'h1E, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hFEFD_4110, 1'b1);
    tbl_a[6]  = mk(4'd0, 5'h1F, 4'd2, 5'h1E, 32'hF0F0_F0F0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tbl_a[7]  = mk(4'd0, 5'h1F, 4'd2, 5'h1B, 32'hFF00_FF00, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tbl_a[8]  = mk(4'd2, 5'h1A, 4'd0, 5'h1F, 32'h0,         4'hF,    32'h000F_000F, 1'b1);
    tbl_a[9]  = mk(4'd2, 5'h1F, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hFFFF_FFFF, 1'b0);
    tbl_a[10] = mk(4'd0, 5'h1F, 4'd7, 5'h18, 32'h5A5A_5A5A, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    tbl_a[11] = mk(4'd7, 5'h1B, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hA5A5_A5A5, 1'b1);
    tbl_a[12] = mk(4'd7, 5'h1C, 4'd7, 5'h1D, 32'h0000_FFFF, 4'b0000, 32'hA5A5_0000, 1'b1);
    tbl_a[13] = mk(4'd7, 5'h1D, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hFFFF_0000, 1'b1);
    tbl_a[14] = mk(4'd4, 5'h1D, 4'd0, 5'h1F, 32'h0,         4'hF,    32'hFFFF_FFFF, 1'b1);

    // Instance B directed vectors (16-bit words, two byte enables, five banks).
    tbl_b[0] = mk(4'd0, 5'h1F, 4'd5, 5'h1D, 32'h1122, 4'b0000, 32'h0000_FFFF, 1'b0);
    tbl_b[1] = mk(4'd0, 5'h1F, 4'd5, 5'h1D, 32'hAABB, 4'b0010, 32'h0000_FFFF, 1'b0);
    tbl_b[2] = mk(4'd5, 5'h1D, 4'd0, 5'h1F, 32'h0,    4'hF,    32'h0000_EE44, 1'b1);
    tbl_b[3] = mk(4'd5, 5'h1D, 4'd5, 5'h1D, 32'hCCDD, 4'b0001, 32'h0000_3344, 1'b1);
    tbl_b[4] = mk(4'd5, 5'h1D, 4'd0, 5'h1F, 32'h0,    4'hF,    32'h0000_3344, 1'b1);
    tbl_b[5] = mk(4'd0, 5'h1F, 4'd7, 5'h00, 32'hF00F, 4'b0000, 32'h0000_FFFF, 1'b0);
    tbl_b[6] = mk(4'd7, 5'h0F, 4'd0, 5'h1F, 32'h0,    4'hF,    32'h0000_0FF0, 1'b1);
    tbl_b[7] = mk(4'd7, 5'h00, 4'd0, 5'h1F, 32'h0,    4'hF,    32'h0000_0FF0, 1'b1);
    tbl_b[8] = mk(4'd7, 5'h1F, 4'd0, 5'h1F, 32'h0,    4'hF,    32'h0000_FFFF, 1'b0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, mk(4'd0, 5'h1F, 4'd0, 5'h1F, 32'h0, 4'hF, 32'h0, 1'b0));
    drive(1'b1, mk(4'd0, 5'h1F, 4'd0, 5'h1F, 32'h0, 4'hF, 32'h0, 1'b0));

    @(negedge clk);
    check_reset(1'b0, "reset_a");
    check_reset(1'b1, "reset_b");

    run_clear(1'b0);
    read_all(1'b0, "post_clear_a");

    for (int i = 0; i < 15; i++) begin
      apply(1'b0, tbl_a[i], $sformatf("vec_a%0d", i));
    end

    // Reset mid-RUN while a read result is on the bus.
    apply(1'b0, tbl_a[5], "pre_reset_read");
    @(negedge clk);
    drive(1'b0, mk(4'd0, 5'h1F, 4'd0, 5'h1F, 32'h0, 4'hF, 32'h0, 1'b0));
    #2;
    rst_a = 1'b0;
    #1;
    check_reset(1'b0, "mid_reset_a");
    run_clear(1'b0);
    read_all(1'b0, "post_reset_a");

    run_clear(1'b1);
    read_all(1'b1, "post_clear_b");
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, tbl_b[i], $sformatf("vec_b%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
